// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller: FSM states, collision
// classes, headings and small direction helpers.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_GROW = 2'b10,
    ST_OVER = 2'b11
  } state_e;

  // Code 2'b11 is not named: any code with bit 1 set is handled as a wall.
  typedef enum logic [1:0] {
    COL_NO    = 2'b00,
    COL_APPLE = 2'b01,
    COL_WALL  = 2'b10
  } coll_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

  function automatic dir_e btn_to_dir(input logic [3:0] btn, input dir_e held);
    if (btn[3])      return DIR_UP;
    else if (btn[2]) return DIR_DOWN;
    else if (btn[1]) return DIR_LEFT;
    else if (btn[0]) return DIR_RIGHT;
    else             return held;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-tick generator: counts 0..period-1 while enabled and pulses on the last
// count. Defining SNAKE_SPEEDUP_EN shortens the period as the score rises.
module snake_tick_gen
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] score,
  output logic       move_tick
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] PERIOD_MAX = CW'(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_s;

`ifdef SNAKE_SPEEDUP_EN
  localparam int STEP  = TICK_DIV >> 4;
  localparam int FLOOR = TICK_DIV >> 2;

  logic [CW-1:0] period_q, period_d;
  logic [31:0]   dec_s;

  // New period is only adopted at a wrap, so a running interval never changes length.
  always_comb begin
    dec_s    = 32'(score >> 2) * 32'(STEP);
    period_d = period_q;
    if (clear) begin
      period_d = PERIOD_MAX;
    end else if (move_tick) begin
      if (dec_s > 32'(TICK_DIV - FLOOR)) period_d = CW'(FLOOR);
      else                               period_d = CW'(32'(TICK_DIV) - dec_s);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) period_q <= PERIOD_MAX;
    else       period_q <= period_d;
  end

  assign period_s = period_q;
`else
  logic unused_score_s;
  assign unused_score_s = ^score;
  assign period_s       = PERIOD_MAX;
`endif

  assign move_tick = enable && (cnt_q == period_s - CW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)          cnt_d = '0;
    else if (move_tick) cnt_d = '0;
    else if (enable)    cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game controller: game FSM, heading, score and length bookkeeping.
// Optional macro SNAKE_SPEEDUP_EN enables score-dependent speedup in snake_tick_gen.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] dir_btn,
  input  logic [1:0] collision,
  output logic       move_tick,
  output logic [1:0] dir,
  output logic       grow,
  output logic       apple_respawn,
  output logic [7:0] score,
  output logic [5:0] length,
  output logic       playing,
  output logic       game_over
);

  localparam logic [5:0] INIT_LEN_W = 6'(INIT_LEN);
  localparam logic [5:0] MAX_LEN_W  = 6'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [5:0] len_q, len_d;
  dir_e       dir_q, dir_d, pend_q, pend_d;
  logic       armed_q, armed_d;
  logic       start_play_s;
  logic       tick_s;

  always_comb begin
    state_d      = state_q;
    start_play_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_PLAY;
          start_play_s = 1'b1;
        end
      end
      ST_PLAY: begin
        if (collision[1])                                   state_d = ST_OVER;
        else if (coll_e'(collision) == COL_APPLE && armed_q) state_d = ST_GROW;
      end
      ST_GROW: state_d = ST_PLAY;
      ST_OVER: if (start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A tick re-arms even when it coincides with entering GROW: the snake has moved on.
  always_comb begin
    score_d = score_q;
    len_d   = len_q;
    dir_d   = dir_q;
    pend_d  = btn_to_dir(dir_btn, pend_q);
    armed_d = armed_q;
    if (start_play_s) begin
      score_d = 8'd0;
      len_d   = INIT_LEN_W;
    end else if (state_q == ST_GROW) begin
      if (score_q != 8'd255)  score_d = score_q + 8'd1;
      if (len_q < MAX_LEN_W)  len_d   = len_q + 6'd1;
    end
    if (start_play_s)                                 dir_d = DIR_RIGHT;
    else if (tick_s && pend_q != reverse_dir(dir_q)) dir_d = pend_q;
    if (tick_s)                                             armed_d = 1'b1;
    else if (state_q == ST_PLAY && state_d == ST_GROW)      armed_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      score_q <= 8'd0;
      len_q   <= INIT_LEN_W;
      dir_q   <= DIR_RIGHT;
      pend_q  <= DIR_RIGHT;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      armed_q <= armed_d;
    end
  end

  snake_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .enable    (playing),
    .clear     (start_play_s),
    .score     (score_q),
    .move_tick (tick_s)
  );

  assign move_tick     = tick_s;
  assign dir           = dir_q;
  assign grow          = (state_q == ST_GROW);
  assign apple_respawn = (state_q == ST_GROW);
  assign score         = score_q;
  assign length        = len_q;
  assign playing       = (state_q == ST_PLAY) || (state_q == ST_GROW);
  assign game_over     = (state_q == ST_OVER);

endmodule
